sr_request_conditioner: RTL
===========================

// Module: sr_request_conditioner
// PURPOSE
//  Upstream stage for the SR flip-flop: turns two raw async request lines (set/clear,
//  e.g. buttons) into clean, registered, mutually exclusive S/R pulses.
//  Does 2-FF synchronisation, per-channel debounce, rising-edge detection,
//  set/clear arbitration and hold-off, so the flip-flop never sees S=R=1.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synced cycles before debounced level changes (>=1)
//  PULSE_CYCLES     1  cycles S or R is held high per request (>=1)
//  HOLDOFF_CYCLES   2  dead cycles after each pulse, S=R=0 (>=0)
//  SET_PRIORITY     1  1: set wins simultaneous requests; 0: clear wins
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  synchronous reset, active high
//  set_in    in   1  raw set request, asynchronous, may bounce
//  clr_in    in   1  raw clear request, asynchronous, may bounce
//  S         out  1  set pulse to flip-flop, registered
//  R         out  1  reset pulse to flip-flop, registered
//  busy      out  1  high while FSM not in IDLE
//  conflict  out  1  only with SR_CONFLICT_DETECT_EN; 1-cycle flag
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): S=0, R=0, busy=0, conflict=0, sync FFs=0, debounced
//    levels=0, counters=0, pending flags=0, FSM=IDLE. Reset mid-pulse kills pulse next edge.
//  - Sync: 2 FFs per channel. Debounce: counter (width $clog2(DEBOUNCE_CYCLES+1)) counts
//    while synced != debounced level, clears on any mismatch break; at DEBOUNCE_CYCLES
//    debounced level takes synced value. Glitch < DEBOUNCE_CYCLES cycles: no effect.
//  - Request = debounced rising edge only; falling edges ignored. Sets a 1-deep
//    pending flag per channel; new edge while flag set is dropped (no queueing beyond 1).
//  - Latency: S/R high exactly DEBOUNCE_CYCLES+3 edges after first edge sampling raw=1
//    (bounce-free input, FSM IDLE).
//  - FSM states: IDLE, SET_PULSE, CLR_PULSE, HOLDOFF.
//    IDLE: only set pending -> SET_PULSE; only clr pending -> CLR_PULSE; both -> winner
//      per SET_PRIORITY; none -> stay. Entering state clears that channel's pending flag.
//    SET_PULSE: S=1 for PULSE_CYCLES, then HOLDOFF (or IDLE if HOLDOFF_CYCLES=0).
//    CLR_PULSE: R=1 for PULSE_CYCLES, same exit.
//    HOLDOFF: S=R=0 for HOLDOFF_CYCLES, then IDLE.
//  - Requests arriving in PULSE/HOLDOFF are latched and served from IDLE afterwards.
//  - Invariant: S&R never 1 on any cycle. Same channel re-request never extends a pulse.
//  - busy=1 in SET_PULSE/CLR_PULSE/HOLDOFF; registered with state.
// CONFIGURATION
//  SR_CONFLICT_DETECT_EN defined: when both pending in IDLE, winner served, loser pending
//    flag cleared (dropped), conflict=1 for one cycle aligned with first S/R cycle.
//  Not defined: no conflict port; loser stays pending and is served after winner's HOLDOFF.
// TESTING  (defaults: DEBOUNCE=4, PULSE=1, HOLDOFF=2, SET_PRIORITY=1)
//  1 Reset: rst=1 5 cycles with set_in=1 -> S=R=busy=0 throughout; release -> S=1 7 edges later.
//  2 Clean set: set_in 0->1 held 10 cycles -> S=1 exactly 1 cycle at edge 7, R=0, busy 3 cycles.
//  3 Bounce: set_in high 3 cycles, low 1, high 3, low -> no S pulse ever.
//  4 Simultaneous: set_in,clr_in rise same cycle -> S pulse edge 7, R pulse edge 10
//    (macro off); macro on -> S only, conflict=1 at edge 7, no R.
//  5 Back-to-back: clr_in rises 2 cycles after set_in -> S at 7, R at 10, never overlap.
//  6 Reset mid-op: rst asserted on S=1 cycle -> S=0 next edge, pending clr dropped, IDLE.

Source files
------------

// File: rtl/sr_request_conditioner_if.sv
// Request/pulse bundle between the raw request source and sr_request_conditioner.
// Optional feature macro: SR_CONFLICT_DETECT_EN adds the conflict flag.
interface sr_request_conditioner_if;
    logic set_in;
    logic clr_in;
    logic S;
    logic R;
    logic busy;
`ifdef SR_CONFLICT_DETECT_EN
    logic conflict;

    modport master (output set_in, clr_in, input S, R, busy, conflict);
    modport slave  (input set_in, clr_in, output S, R, busy, conflict);
`else
    modport master (output set_in, clr_in, input S, R, busy);
    modport slave  (input set_in, clr_in, output S, R, busy);
`endif
endinterface

// File: rtl/sr_request_conditioner.sv
// sr_request_conditioner: synchronises and debounces two raw request lines and turns
// their rising edges into registered, mutually exclusive S/R pulses with hold-off.
// Optional feature macro: SR_CONFLICT_DETECT_EN (drop the losing request on a
// simultaneous set/clear and flag it on the conflict output).
module sr_request_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 1,
    parameter int unsigned HOLDOFF_CYCLES  = 2,
    parameter int unsigned SET_PRIORITY    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    sr_request_conditioner_if.slave  bus
);

    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DEB_LAST  = DEBOUNCE_CYCLES - 1;
    localparam int unsigned TMR_MAX   = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam int unsigned PULSE_LAST = PULSE_CYCLES - 1;
    localparam int unsigned HOLD_LAST  = (HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        CLR_PULSE = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    // Channel index 0 = set, 1 = clear throughout.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][DEB_W-1:0] dcnt_q, dcnt_d;
    logic [1:0]            rise;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            take;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  arb;
    logic                  s_q, s_d;
    logic                  r_q, r_d;
    logic                  busy_q, busy_d;
`ifdef SR_CONFLICT_DETECT_EN
    logic                  conflict_q, conflict_d;
`endif

    // Debounce: level follows the synced input only after DEBOUNCE_CYCLES stable mismatches.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_W'(DEB_LAST)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
                end
            end
        end
        rise = deb_d & ~deb_q;
    end

    // Next state: pulse/holdoff timing; expiry arbitrates like IDLE so queued work starts at once.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        arb     = 1'b0;
        take    = 2'b00;
`ifdef SR_CONFLICT_DETECT_EN
        conflict_d = 1'b0;
`endif
        case (state_q)
            IDLE: arb = 1'b1;
            SET_PULSE, CLR_PULSE: begin
                if (tmr_q == TMR_W'(PULSE_LAST)) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        arb = 1'b1;
                    end else begin
                        state_d = HOLDOFF;
                        tmr_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            HOLDOFF: begin
                if (tmr_q == TMR_W'(HOLD_LAST)) begin
                    arb = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb) begin
            state_d = IDLE;
            tmr_d   = '0;
            if (pend_q[0] && (!pend_q[1] || (SET_PRIORITY != 0))) begin
                state_d = SET_PULSE;
                take[0] = 1'b1;
            end else if (pend_q[1]) begin
                state_d = CLR_PULSE;
                take[1] = 1'b1;
            end
`ifdef SR_CONFLICT_DETECT_EN
            if (pend_q == 2'b11) begin
                take       = 2'b11;
                conflict_d = 1'b1;
            end
`endif
        end

        pend_d = (pend_q & ~take) | rise;
        s_d    = (state_d == SET_PULSE);
        r_d    = (state_d == CLR_PULSE);
        busy_d = (state_d != IDLE);
    end

    // State, synchroniser, debounce and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            dcnt_q  <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            tmr_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SR_CONFLICT_DETECT_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            sync1_q <= {bus.clr_in, bus.set_in};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
`ifdef SR_CONFLICT_DETECT_EN
            conflict_q <= conflict_d;
`endif
        end
    end

    assign bus.S    = s_q;
    assign bus.R    = r_q;
    assign bus.busy = busy_q;
`ifdef SR_CONFLICT_DETECT_EN
    assign bus.conflict = conflict_q;
`endif

endmodule
